// File: rtl/display_scan_ctrl.sv
// Scan controller for a 5-digit multiplexed seven-segment display.
// Counters slice time into digit slots and brightness phases; frame-buffered data drives active-low An/Seg/Dp.
module display_scan_ctrl #(
  parameter int STEP = 6250,
  parameter int SW   = 13
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        En,
  input  logic [19:0] Data,
  input  logic [4:0]  Dp_In,
  input  logic        Blank_Lz,
  input  logic [3:0]  Bright,
  output logic [4:0]  An,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic        Frame_Done
);

  logic [SW-1:0] sub_q;
  logic [3:0]    phase_q;
  logic [2:0]    digit_q;

  logic [19:0]   data_q;
  logic [4:0]    dp_q;
  logic          lz_q;
  logic [3:0]    bright_q;

  logic          sub_wrap;
  logic          phase_wrap;
  logic          frame_end;

  logic [19:0]   nib_sh_p0;
  logic          blank_p0;
  logic          vld_p0;
  logic [4:0]    an_p0;
  logic [6:0]    seg_p0;
  logic          dp_p0;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign sub_wrap   = (sub_q == SW'(STEP - 1));
  assign phase_wrap = sub_wrap && (phase_q == 4'd15);
  assign frame_end  = phase_wrap && (digit_q == 3'd4);

  // Stage p0: scan counters, frozen while the display is disabled
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sub_q   <= '0;
      phase_q <= '0;
      digit_q <= '0;
    end else if (En) begin
      sub_q <= sub_wrap ? '0 : sub_q + SW'(1);
      if (sub_wrap)
        phase_q <= phase_q + 4'd1;
      if (phase_wrap)
        digit_q <= (digit_q == 3'd4) ? 3'd0 : digit_q + 3'd1;
    end
  end

  // Shadow copy follows the inputs while dark, otherwise only at frame boundaries
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      data_q   <= '0;
      dp_q     <= '0;
      lz_q     <= 1'b0;
      bright_q <= 4'd15;
    end else if (!En || frame_end) begin
      data_q   <= Data;
      dp_q     <= Dp_In;
      lz_q     <= Blank_Lz;
      bright_q <= Bright;
    end
  end

  always_comb begin
    nib_sh_p0 = data_q >> {digit_q, 2'b00};
    blank_p0  = lz_q && (digit_q != 3'd0) && (nib_sh_p0 == '0);
    vld_p0    = En && (phase_q <= bright_q) && !blank_p0;
    an_p0     = '1;
    seg_p0    = '1;
    dp_p0     = 1'b1;
    if (vld_p0) begin
      an_p0[digit_q] = 1'b0;
      seg_p0         = hex7(nib_sh_p0[3:0]);
      dp_p0          = ~dp_q[digit_q];
    end
  end

  // Stage p1: registered display drive
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      An         <= '1;
      Seg        <= '1;
      Dp         <= 1'b1;
      Frame_Done <= 1'b0;
    end else begin
      An         <= an_p0;
      Seg        <= seg_p0;
      Dp         <= dp_p0;
      Frame_Done <= En && frame_end;
    end
  end

endmodule
